// File: rtl/fifo_cola_if.sv
// fifo_cola_if: handshake bundle between a fifo_cola queue and its user.
//
// Signals:
//   push, pop      write / read strobes driven by the user
//   data_in        write data driven by the user
//   data_out       registered head word presented by the queue
//   empty, full    occupancy flags (count == 0 / count == DEPTH)
//   almost_empty   count <= AE_MARGIN
//   almost_full    count >= DEPTH - AF_MARGIN
//   count          current occupancy, 0..DEPTH
//   error          sticky overflow/underflow indication
//
// Modports:
//   master  the user side (input channel writer or arbiter reader)
//   slave   the queue itself
interface fifo_cola_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2
);
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count;
  logic                  error;

  modport master (
    output push, pop, data_in,
    input  data_out, empty, full, almost_empty, almost_full, count, error
  );

  modport slave (
    input  push, pop, data_in,
    output data_out, empty, full, almost_empty, almost_full, count, error
  );
endinterface

// File: rtl/fifo_cola.sv
// fifo_cola: single-clock packet queue placed in front of the arbitration
// stage (and reused for the output queues). The popped word appears on
// data_out one cycle after the accepting pop edge; its top two bits carry
// the destination.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears pointers, count, data_out, error
//   bus    fifo_cola_if.slave: push/pop/data_in in, data_out/flags/count/
//          error out
//
// All outputs are driven from registers (data_out, count, error) or decoded
// from the registered count only, so push/pop never reach an output
// combinationally.
module fifo_cola #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1
) (
  input logic        clk,
  input logic        reset,
  fifo_cola_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_LEVEL   = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_WIDTH:0] AE_LEVEL   = (ADDR_WIDTH+1)'(AE_MARGIN);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  error_q;

  logic pop_ok;
  logic push_ok;

  // A pop needs something to read. A push needs room, except that a pop
  // accepted on the same edge frees the head slot, so a full queue can
  // take a push together with a pop. An empty queue never bypasses the
  // pushed word to data_out.
  assign pop_ok  = bus.pop && (count_q != '0);
  assign push_ok = bus.push && ((count_q != FULL_LEVEL) || pop_ok);

  // Storage is not cleared on reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // Pointers, occupancy, read register and sticky error. Pointers roll
  // over naturally at ADDR_WIDTH bits. A rejected strobe (overflow or
  // underflow) sets error until the next reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      data_q  <= '0;
      error_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        data_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - 1'b1;
      end
      if ((bus.push && !push_ok) || (bus.pop && !pop_ok)) begin
        error_q <= 1'b1;
      end
    end
  end

  assign bus.data_out     = data_q;
  assign bus.count        = count_q;
  assign bus.error        = error_q;
  assign bus.empty        = (count_q == '0);
  assign bus.full         = (count_q == FULL_LEVEL);
  assign bus.almost_empty = (count_q <= AE_LEVEL);
  assign bus.almost_full  = (count_q >= AF_LEVEL);

endmodule

// File: doc/fifo_cola.md
Name: fifo_cola

Overview:
- Synchronous single-clock FIFO that buffers packets for one input channel.
- Four instances sit directly upstream of the arbitration stage.
- Each instance provides its empty flag, accepts the arbiter's pop strobe, and presents the popped word, whose top two bits are the destination, one cycle after the pop.
- The same block is reused for the four output queues, which are driven by push and report full.

Parameters:
- DATA_WIDTH, 6, word width; bits [DATA_WIDTH-1:DATA_WIDTH-2] carry the destination.
- ADDR_WIDTH, 2, pointer width; DEPTH = 2**ADDR_WIDTH = 4 entries.
- AF_MARGIN, 1, almost_full asserted when count >= DEPTH-AF_MARGIN.
- AE_MARGIN, 1, almost_empty asserted when count <= AE_MARGIN.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- push  input  1  write strobe; data_in written on the edge if accepted.
- pop  input  1  read strobe; head word transferred to data_out on the edge if accepted.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data; holds its value between pops.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- almost_empty  output  1  count <= AE_MARGIN.
- almost_full  output  1  count >= DEPTH-AF_MARGIN.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- error  output  1  sticky overflow/underflow flag.

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array, write pointer wr_ptr, read pointer rd_ptr, occupancy counter count. Pointers wrap modulo DEPTH (natural ADDR_WIDTH rollover).
- Reset, when reset=1 at an edge; it overrides push/pop in the same cycle:
  - wr_ptr=0, rd_ptr=0, count=0, data_out=0, error=0.
  - Flags then read empty=1, full=0, almost_empty=1, almost_full=0.
  - Array contents are don't-care and are not cleared.
- Flags are combinational decodes of the registered count, so they reflect the new occupancy in the cycle after the accepting edge.
- Push accepted when push=1 and (count<DEPTH, or pop is also accepted in the same cycle). On acceptance: mem[wr_ptr]<=data_in, then wr_ptr+1.
- Pop accepted when pop=1 and count>0. On acceptance: data_out<=mem[rd_ptr], then rd_ptr+1.
- Read latency is 1 cycle: the word popped at edge N is on data_out during cycle N+1, when the arbiter's PUSH state samples the destination.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both accepted: unchanged.
  - neither: unchanged.
- Simultaneous push+pop:
  - count==0: push accepted, pop rejected (no bypass; data_out unchanged); error<=1; count becomes 1.
  - count==DEPTH: both accepted; count stays DEPTH, full stays 1; the popped word is the old head; the new word lands in the freed slot.
  - otherwise: both accepted, count unchanged.
- Overflow: push=1 at count==DEPTH with no pop. Word dropped, pointers and count unchanged, error<=1.
- Underflow: pop=1 at count==0. No pointer change, data_out holds, error<=1.
- error is sticky and clears only on reset.
- Reset mid-operation: all in-flight contents are discarded; the first push after reset lands in mem[0]; no stale word ever appears on data_out, which stays 0 until the first accepted pop.
- No combinational path from push/pop to any output.

Test Plan:
- Reset then idle:
  - Hold reset=1 for 2 cycles, then release.
  - Required: data_out=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, error=0.
- Fill:
  - Push 6'h11, 6'h22, 6'h33, 6'h04 on consecutive edges.
  - Required count after each edge: 1,2,3,4.
  - almost_empty drops after the 2nd push; almost_full rises after the 3rd; full=1 after the 4th; error=0.
- Overflow then drain:
  - At full, push 6'h3F.
  - Required: count stays 4, error=1.
  - Then pop 4 times.
  - Required: data_out equals 6'h11, 6'h22, 6'h33, 6'h04 on the cycle after each pop; destination bits [5:4] are 01, 10, 11, 00; 6'h3F never appears; empty=1 at the end.
- Underflow:
  - Pop at empty.
  - Required: data_out unchanged, count=0, error=1.
- Simultaneous push and pop at the boundaries:
  - At full, push 6'h15 and pop together.
  - Required: old head on data_out, count=4; the following 4 pops end with 6'h15.
  - At empty, push 6'h2A and pop together.
  - Required: count=1, data_out unchanged, error=1.
- Wrap-around and reset mid-operation:
  - Run 10 interleaved push/pop pairs across the pointer wrap; all words must emerge in order.
  - With count=3, assert reset for 1 cycle together with push=1.
  - Required: next cycle count=0, empty=1, error=0.
  - Then push 6'h07 and pop it.
  - Required: data_out=6'h07.
